// File: rtl/board_ctrl_unit.sv
// rtl/board_ctrl_unit.sv - front-panel switch conditioning, speed select and CPU tick generation (optional single-step: BOARD_CTRL_STEP_EN)
module board_ctrl_unit #(
    parameter int SW_W            = 16,
    parameter int BASE_PERIOD     = 100000000,
    parameter int NUM_SPEEDS      = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int OP_W            = 3,
    parameter int ADDR_W          = 10,
    localparam int SPD_W          = (NUM_SPEEDS > 1) ? $clog2(NUM_SPEEDS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SW_W-1:0]   sw,
    output logic              tick,
    output logic              go,
    output logic              cpu_rst,
    output logic [SPD_W-1:0]  speed_idx,
    output logic [OP_W-1:0]   display_op,
    output logic [ADDR_W-1:0] ram_display_addr
);

    // Longest period is the slowest speed; the tick counter must hold its terminal value.
    localparam longint MAX_PERIOD = longint'(BASE_PERIOD) << (NUM_SPEEDS - 1);
    localparam int     CNT_W      = (MAX_PERIOD > 1) ? $clog2(MAX_PERIOD) : 1;
    localparam int     DEB_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    // Switch bit positions
    localparam int BIT_GO    = 0;
    localparam int BIT_RST   = 1;
    localparam int BIT_STEP  = 2;
    localparam int BIT_OP    = 3;
    localparam int BIT_ADDR  = 3 + OP_W;

    logic [SW_W-1:0]  sync1_q;
    logic [SW_W-1:0]  sync2_q;
    logic [SW_W-1:0]  sample_q;
    logic [SW_W-1:0]  deb_q;
    logic [SW_W-1:0]  deb_d;
    logic [DEB_W-1:0] sample_cnt_q;
    logic             sample_wrap;

    logic             step_prev_q;
    logic             step_rise;
    logic             single_step;
    logic             speed_step;
    logic [SPD_W-1:0] speed_q;
    logic [SPD_W-1:0] speed_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] term_cnt;
    logic             tick_q;

    // Two-flop synchroniser on the whole raw switch bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sw;
            sync2_q <= sync1_q;
        end
    end

    assign sample_wrap = (sample_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1));

    // A debounced bit follows the synced bus only when two consecutive samples agree
    always_comb begin
        deb_d = deb_q;
        if (sample_wrap) begin
            for (int i = 0; i < SW_W; i++) begin
                if (sync2_q[i] == sample_q[i]) begin
                    deb_d[i] = sync2_q[i];
                end
            end
        end
    end

    // Sample interval counter, sample capture and debounced register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt_q <= '0;
            sample_q     <= '0;
            deb_q        <= '0;
        end else begin
            if (sample_wrap) begin
                sample_cnt_q <= '0;
                sample_q     <= sync2_q;
            end else begin
                sample_cnt_q <= sample_cnt_q + DEB_W'(1);
            end
            deb_q <= deb_d;
        end
    end

    assign go               = deb_q[BIT_GO];
    assign cpu_rst          = deb_q[BIT_RST];
    assign display_op       = deb_q[BIT_OP +: OP_W];
    assign ram_display_addr = deb_q[BIT_ADDR +: ADDR_W];

    assign step_rise = deb_q[BIT_STEP] & ~step_prev_q;

`ifdef BOARD_CTRL_STEP_EN
    // While paused and out of reset the step switch issues one tick instead of changing speed.
    assign single_step = step_rise & ~go & ~cpu_rst;
`else
    assign single_step = 1'b0;
`endif

    assign speed_step = step_rise & ~single_step;
    assign speed_d    = (speed_q == SPD_W'(NUM_SPEEDS - 1)) ? '0 : speed_q + SPD_W'(1);
    assign term_cnt   = CNT_W'((64'(BASE_PERIOD) << speed_q) - 64'd1);

    // Speed select and tick generation; a speed change outranks reset hold and terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_prev_q <= 1'b0;
            speed_q     <= '0;
            cnt_q       <= '0;
            tick_q      <= 1'b0;
        end else begin
            step_prev_q <= deb_q[BIT_STEP];
            if (speed_step) begin
                speed_q <= speed_d;
                cnt_q   <= '0;
                tick_q  <= 1'b0;
            end else if (cpu_rst) begin
                cnt_q  <= '0;
                tick_q <= 1'b0;
            end else if (go) begin
                if (cnt_q == term_cnt) begin
                    cnt_q  <= '0;
                    tick_q <= 1'b1;
                end else begin
                    cnt_q  <= cnt_q + CNT_W'(1);
                    tick_q <= 1'b0;
                end
            end else begin
                tick_q <= single_step;
            end
        end
    end

    assign tick      = tick_q;
    assign speed_idx = speed_q;

endmodule

// File: tb/tb_board_ctrl_unit.sv
// tb/tb_board_ctrl_unit.sv - self-checking bench for board_ctrl_unit
module tb_board_ctrl_unit;

    localparam int SW_W            = 16;
    localparam int BASE_PERIOD     = 4;
    localparam int NUM_SPEEDS      = 4;
    localparam int DEBOUNCE_CYCLES = 2;
    localparam int OP_W            = 3;
    localparam int ADDR_W          = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [SW_W-1:0]   sw = '0;
    logic              tick;
    logic              go;
    logic              cpu_rst;
    logic [1:0]        speed_idx;
    logic [OP_W-1:0]   display_op;
    logic [ADDR_W-1:0] ram_display_addr;

    int checks = 0;
    int errors = 0;
    int exp_spd = 0;

    // Reference tick model: ticks come after exactly (BASE_PERIOD << speed) running cycles
    int       run_cnt = 0;
    bit       have_prev = 0;
    bit       mon_en = 1;
    logic     pgo, prst;
    logic [1:0] pspd;

    board_ctrl_unit #(
        .SW_W(SW_W), .BASE_PERIOD(BASE_PERIOD), .NUM_SPEEDS(NUM_SPEEDS),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .OP_W(OP_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .tick(tick), .go(go), .cpu_rst(cpu_rst),
        .speed_idx(speed_idx), .display_op(display_op), .ram_display_addr(ram_display_addr)
    );

    always #5 clk = ~clk;

    // Cycle-level tick monitor driven by the observed control outputs
    always @(negedge clk) begin
        logic exp_tick;
        if (!rst_n) begin
            run_cnt   = 0;
            have_prev = 0;
            checks++;
            if (tick !== 1'b0) begin
                errors++;
                $display("FAIL tick_in_reset: got %b want 0", tick);
            end
        end else begin
            if (have_prev) begin
                exp_tick = 1'b0;
                if (speed_idx !== pspd) begin
                    run_cnt = 0;
                end else if (prst) begin
                    run_cnt = 0;
                end else if (pgo) begin
                    run_cnt++;
                    if (run_cnt == (BASE_PERIOD << pspd)) begin
                        exp_tick = 1'b1;
                        run_cnt  = 0;
                    end
                end
                if (mon_en) begin
                    checks++;
                    if (tick !== exp_tick) begin
                        errors++;
                        $display("FAIL tick_model at %0t: got %b want %b", $time, tick, exp_tick);
                    end
                end
            end
            pgo       = go;
            prst      = cpu_rst;
            pspd      = speed_idx;
            have_prev = 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_go(input logic val, input int bound, output int n);
        n = 0;
        while (go !== val && n <= bound) begin
            cyc(1);
            n++;
        end
    endtask

    task automatic wait_rst(input logic val, input int bound, output int n);
        n = 0;
        while (cpu_rst !== val && n <= bound) begin
            cyc(1);
            n++;
        end
    endtask

    task automatic cycles_to_tick(output int n);
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (tick !== 1'b1 && n < 100);
    endtask

    task automatic measure_spacing(output int sp);
        int n;
        n = 0;
        while (tick !== 1'b1 && n < 100) begin
            cyc(1);
            n++;
        end
        if (tick !== 1'b1) begin
            sp = -1;
        end else begin
            cycles_to_tick(sp);
            if (tick !== 1'b1) sp = -1;
        end
    endtask

    task automatic test_reset;
        int n;
        rst_n = 1'b0;
        sw    = '0;
        cyc(3);
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL rst_tick: got %b want 0", tick); end
        checks++; if (go !== 1'b0) begin errors++; $display("FAIL rst_go: got %b want 0", go); end
        checks++; if (cpu_rst !== 1'b0) begin errors++; $display("FAIL rst_cpu_rst: got %b want 0", cpu_rst); end
        checks++; if (speed_idx !== 2'd0) begin errors++; $display("FAIL rst_speed: got %0d want 0", speed_idx); end
        checks++; if (display_op !== '0) begin errors++; $display("FAIL rst_op: got %0h want 0", display_op); end
        checks++; if (ram_display_addr !== '0) begin errors++; $display("FAIL rst_addr: got %0h want 0", ram_display_addr); end
        rst_n = 1'b1;
        n = 0;
        repeat (100) begin
            cyc(1);
            if (tick === 1'b1) n++;
        end
        checks++; if (n != 0) begin errors++; $display("FAIL idle_ticks: got %0d want 0", n); end
        checks++; if (go !== 1'b0) begin errors++; $display("FAIL idle_go: got %b want 0", go); end
    endtask

    task automatic test_run_speed;
        int n, sp;
        sw[0] = 1'b1;
        wait_go(1'b1, 20, n);
        checks++; if (go !== 1'b1 || n > 8) begin errors++; $display("FAIL go_latency: got %0d cycles go=%b want <=8", n, go); end
        measure_spacing(sp);
        checks++; if (sp != BASE_PERIOD) begin errors++; $display("FAIL spacing_s0: got %0d want %0d", sp, BASE_PERIOD); end
        for (int k = 1; k <= 4; k++) begin
            sw[2] = 1'b1;
            cyc(10);
            sw[2] = 1'b0;
            cyc(10);
            exp_spd = (exp_spd + 1) % NUM_SPEEDS;
            checks++; if (speed_idx !== 2'(exp_spd)) begin errors++; $display("FAIL speed_step%0d: got %0d want %0d", k, speed_idx, exp_spd); end
            measure_spacing(sp);
            checks++; if (sp != (BASE_PERIOD << exp_spd)) begin errors++; $display("FAIL spacing_step%0d: got %0d want %0d", k, sp, BASE_PERIOD << exp_spd); end
        end
    endtask

    task automatic test_short_pulse;
        for (int k = 0; k < 4; k++) begin
            cyc($urandom_range(1, 5));
            sw[2] = 1'b1;
            cyc(1);
            sw[2] = 1'b0;
            cyc(12);
            checks++; if (speed_idx !== 2'(exp_spd)) begin errors++; $display("FAIL short_pulse%0d: got %0d want %0d", k, speed_idx, exp_spd); end
        end
    endtask

    task automatic test_pause;
        int n, m, h;
        for (int k = 0; k < 3; k++) begin
            cyc($urandom_range(1, 7));
            sw[0] = 1'b0;
            wait_go(1'b0, 20, n);
            checks++; if (go !== 1'b0 || n > 8) begin errors++; $display("FAIL pause_latency%0d: got %0d cycles go=%b", k, n, go); end
            h = $urandom_range(5, 15);
            n = 0;
            repeat (h) begin
                cyc(1);
                if (tick === 1'b1) n++;
            end
            checks++; if (n != 0) begin errors++; $display("FAIL pause_ticks%0d: got %0d want 0", k, n); end
            m = run_cnt;
            sw[0] = 1'b1;
            wait_go(1'b1, 20, n);
            checks++; if (go !== 1'b1) begin errors++; $display("FAIL resume_go%0d: got %b want 1", k, go); end
            cycles_to_tick(n);
            checks++; if (n != BASE_PERIOD - m) begin errors++; $display("FAIL resume_tick%0d: got %0d want %0d", k, n, BASE_PERIOD - m); end
        end
    endtask

    task automatic test_cpu_rst_fields;
        int n;
        logic [12:0] v;
        cyc($urandom_range(1, 6));
        sw[1] = 1'b1;
        sw[15:3] = 13'h1ABC;
        wait_rst(1'b1, 20, n);
        checks++; if (cpu_rst !== 1'b1 || n > 8) begin errors++; $display("FAIL cpu_rst_latency: got %0d cycles cpu_rst=%b", n, cpu_rst); end
        n = 0;
        repeat (20) begin
            cyc(1);
            if (tick === 1'b1) n++;
        end
        checks++; if (n != 0) begin errors++; $display("FAIL cpu_rst_ticks: got %0d want 0", n); end
        sw[1] = 1'b0;
        wait_rst(1'b0, 20, n);
        checks++; if (cpu_rst !== 1'b0) begin errors++; $display("FAIL cpu_rst_release: got %b want 0", cpu_rst); end
        cycles_to_tick(n);
        checks++; if (n != BASE_PERIOD) begin errors++; $display("FAIL cpu_rst_first_tick: got %0d want %0d", n, BASE_PERIOD); end
        checks++; if (display_op !== 3'b100) begin errors++; $display("FAIL op_1abc: got %b want 100", display_op); end
        checks++; if (ram_display_addr !== 10'h357) begin errors++; $display("FAIL addr_1abc: got %0h want 357", ram_display_addr); end
        for (int k = 0; k < 4; k++) begin
            v = 13'($urandom);
            sw[15:3] = v;
            cyc(10);
            checks++; if (display_op !== v[2:0]) begin errors++; $display("FAIL op_rand%0d: got %0h want %0h", k, display_op, v[2:0]); end
            checks++; if (ram_display_addr !== v[12:3]) begin errors++; $display("FAIL addr_rand%0d: got %0h want %0h", k, ram_display_addr, v[12:3]); end
        end
    endtask

    task automatic test_step_mode;
        int n;
        sw[0] = 1'b0;
        wait_go(1'b0, 20, n);
        checks++; if (go !== 1'b0) begin errors++; $display("FAIL step_go_low: got %b want 0", go); end
        cyc(4);
`ifdef BOARD_CTRL_STEP_EN
        mon_en = 0;
`endif
        n = 0;
        for (int p = 0; p < 2; p++) begin
            sw[2] = 1'b1;
            repeat (10) begin cyc(1); if (tick === 1'b1) n++; end
            sw[2] = 1'b0;
            repeat (10) begin cyc(1); if (tick === 1'b1) n++; end
        end
        mon_en = 1;
`ifdef BOARD_CTRL_STEP_EN
        checks++; if (n != 2) begin errors++; $display("FAIL step_ticks: got %0d want 2", n); end
`else
        exp_spd = (exp_spd + 2) % NUM_SPEEDS;
        checks++; if (n != 0) begin errors++; $display("FAIL step_ticks: got %0d want 0", n); end
`endif
        checks++; if (speed_idx !== 2'(exp_spd)) begin errors++; $display("FAIL step_speed: got %0d want %0d", speed_idx, exp_spd); end
    endtask

    task automatic test_reset_midcount;
        int n;
        sw[0] = 1'b1;
        wait_go(1'b1, 20, n);
        checks++; if (go !== 1'b1) begin errors++; $display("FAIL mid_go_up: got %b want 1", go); end
        cyc($urandom_range(1, 6));
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL mid_rst_tick: got %b want 0", tick); end
        checks++; if (go !== 1'b0) begin errors++; $display("FAIL mid_rst_go: got %b want 0", go); end
        checks++; if (speed_idx !== 2'd0) begin errors++; $display("FAIL mid_rst_speed: got %0d want 0", speed_idx); end
        exp_spd = 0;
        cyc(2);
        rst_n = 1'b1;
        wait_go(1'b1, 20, n);
        checks++; if (go !== 1'b1 || n > 8) begin errors++; $display("FAIL mid_go_latency: got %0d cycles go=%b", n, go); end
        cycles_to_tick(n);
        checks++; if (n != BASE_PERIOD) begin errors++; $display("FAIL mid_first_tick: got %0d want %0d", n, BASE_PERIOD); end
    endtask

    initial begin
        test_reset();
        test_run_speed();
        test_short_pulse();
        test_pause();
        test_cpu_rst_fields();
        test_step_mode();
        test_reset_midcount();
        cyc(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
